// File: rtl/alu_operand_stage.sv
// ALU operand-source stage: selects operand B, registers A/B into a main + skid elastic buffer.
// Optional macro ALU_SRC_STALL_CNT_EN enables the saturating backpressure stall counter.
module alu_operand_stage #(
    parameter int unsigned REGISTER_DATA_BIT_WIDTH = 16,
    parameter int unsigned DATA_2_WIDTH            = 4,
    parameter int unsigned STALL_CNT_WIDTH         = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [REGISTER_DATA_BIT_WIDTH-1:0] data_1,
    input  logic [REGISTER_DATA_BIT_WIDTH-1:0] data_2,
    input  logic [DATA_2_WIDTH-1:0]            imm,
    input  logic [REGISTER_DATA_BIT_WIDTH-1:0] fwd_data,
    input  logic [1:0]                         ALU_Src,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [REGISTER_DATA_BIT_WIDTH-1:0] op_a,
    output logic [REGISTER_DATA_BIT_WIDTH-1:0] op_b,
    output logic [STALL_CNT_WIDTH-1:0]         stall_cnt
);

    localparam int unsigned RW = REGISTER_DATA_BIT_WIDTH;
    localparam int unsigned DW = DATA_2_WIDTH;

    logic [RW-1:0] imm_sext, imm_zext, sel_b;

    generate
        if (DW < 1 || DW > RW) begin : g_bad_imm_width
            $error("DATA_2_WIDTH must lie in 1..REGISTER_DATA_BIT_WIDTH");
        end else if (DW == RW) begin : g_imm_full
            assign imm_sext = imm;
            assign imm_zext = imm;
        end else begin : g_imm_ext
            assign imm_sext = {{(RW - DW){imm[DW-1]}}, imm};
            assign imm_zext = {{(RW - DW){1'b0}}, imm};
        end
    endgenerate

    always_comb begin
        unique case (ALU_Src)
            2'b00:   sel_b = data_2;
            2'b01:   sel_b = imm_sext;
            2'b10:   sel_b = imm_zext;
            default: sel_b = fwd_data;
        endcase
    end

    logic          main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [RW-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [RW-1:0] skid_a_q, skid_a_d, skid_b_q, skid_b_d;
    logic          accept, pop;

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        skid_a_d     = skid_a_q;
        skid_b_d     = skid_b_q;
        if (flush) begin
            // Data registers deliberately hold; only the valid flags are cleared.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_valid_d = 1'b1;
                op_a_d       = data_1;
                op_b_d       = sel_b;
            end
        end else if (pop) begin
            if (skid_valid_q) begin
                op_a_d       = skid_a_q;
                op_b_d       = skid_b_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                op_a_d = data_1;
                op_b_d = sel_b;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_a_d     = data_1;
            skid_b_d     = sel_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            skid_a_q     <= skid_a_d;
            skid_b_q     <= skid_b_d;
        end
    end

`ifdef ALU_SRC_STALL_CNT_EN
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;

    // Saturating; flush does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (main_valid_q && !out_ready && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_WIDTH'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
